// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: queues result words and streams them to the uart_tx
// byte transmitter, one frame per byte, least-significant byte first.
// A word FIFO decouples the producer from the serial rate. A small FSM
// presents each byte, pulses the active-low start and then waits for the
// transmitter's end-of-frame pulse. A timer aborts the rest of a word if
// the transmitter never answers.
module uart_tx_sequencer #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk_uart,
    input  logic                          rst,
    input  logic [WORD_W-1:0]             word_i,
    input  logic                          word_valid_i,
    output logic                          word_ready_o,
    output logic                          enable_tx_o,
    output logic [7:0]                    uart_byte_o,
    input  logic                          finished_tx_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          timeout_err_o,
    output logic [15:0]                   words_sent_o
);

    localparam int BYTES = WORD_W / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Word FIFO storage and bookkeeping
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] head;

    // Sequencer state
    state_t            state;
    logic [WORD_W-1:0] shift;
    logic [WORD_W-1:0] shifted;
    logic [IDX_W-1:0]  byte_idx;
    logic [TMR_W-1:0]  timer;

    // Ready is derived from the registered count only, so it never depends
    // on the same-cycle pop; a full FIFO refuses a word even while popping.
    assign word_ready_o = (count < CNT_FULL);
    assign push         = word_valid_i && word_ready_o;
    // The FSM only takes a new word once the previous one has completed or aborted.
    assign pop          = (state == IDLE) && (count != '0);
    assign head         = mem[rd_ptr];
    assign shifted      = shift >> 8;
    assign fifo_count_o = count;
    assign busy_o       = (state != IDLE);

    // FIFO storage write; data needs no reset since count gates every read
    always_ff @(posedge clk_uart) begin
        if (push) begin
            mem[wr_ptr] <= word_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk_uart) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Byte sequencer: pop a word, then SETUP -> START -> WAIT for each byte
    always_ff @(posedge clk_uart) begin
        if (rst) begin
            state         <= IDLE;
            enable_tx_o   <= 1'b1;
            uart_byte_o   <= 8'h00;
            byte_idx      <= '0;
            timer         <= '0;
            timeout_err_o <= 1'b0;
            words_sent_o  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    enable_tx_o <= 1'b1;
                    if (pop) begin
                        // Load the byte now so it is already stable during SETUP,
                        // one full cycle ahead of the start strobe.
                        shift       <= head;
                        uart_byte_o <= head[7:0];
                        byte_idx    <= '0;
                        state       <= SETUP;
                    end
                end

                SETUP: begin
                    uart_byte_o <= shift[7:0];
                    enable_tx_o <= 1'b0;
                    state       <= START;
                end

                START: begin
                    // The strobe is low only while in START, so it lasts one cycle.
                    enable_tx_o <= 1'b1;
                    timer       <= '0;
                    state       <= WAIT;
                end

                WAIT: begin
                    enable_tx_o <= 1'b1;
                    // A finish on the last timer cycle still counts as a normal finish.
                    if (finished_tx_i) begin
                        if (byte_idx == IDX_LAST) begin
                            words_sent_o <= words_sent_o + 16'd1;
                            state        <= IDLE;
                        end else begin
                            shift       <= shifted;
                            uart_byte_o <= shifted[7:0];
                            byte_idx    <= byte_idx + IDX_W'(1);
                            state       <= SETUP;
                        end
                    end else if (timer == TMR_LAST) begin
                        // Abandon the remaining bytes of this word; the flag is sticky.
                        timeout_err_o <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                default: begin
                    enable_tx_o <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Testbench for uart_tx_sequencer: a small uart_tx model answers start strobes
// with a finish pulse after a programmable frame time, and a scoreboard queue
// holds the bytes expected on each strobe, filled as words are accepted.
module tb_uart_tx_sequencer;

    localparam int WORD_W     = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int TIMEOUT    = 64;

    logic              clk_uart = 1'b0;
    logic              rst;
    logic [WORD_W-1:0] word_i;
    logic              word_valid_i;
    logic              word_ready_o;
    logic              enable_tx_o;
    logic [7:0]        uart_byte_o;
    logic              finished_tx_i;
    logic              busy_o;
    logic [3:0]        fifo_count_o;
    logic              timeout_err_o;
    logic [15:0]       words_sent_o;

    logic model_fin  = 1'b0;
    logic manual_fin = 1'b0;
    assign finished_tx_i = model_fin | manual_fin;

    int         checks     = 0;
    int         failures   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_exp;
    int         strobe_cnt = 0;
    int         fin_timer  = 0;
    int         frame_len  = 6;
    bit         model_on   = 1'b1;
    logic       prev_en    = 1'b1;

    uart_tx_sequencer #(
        .WORD_W    (WORD_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_uart     (clk_uart),
        .rst          (rst),
        .word_i       (word_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .enable_tx_o  (enable_tx_o),
        .uart_byte_o  (uart_byte_o),
        .finished_tx_i(finished_tx_i),
        .busy_o       (busy_o),
        .fifo_count_o (fifo_count_o),
        .timeout_err_o(timeout_err_o),
        .words_sent_o (words_sent_o)
    );

    always #5 clk_uart = ~clk_uart;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // uart_tx model: on each low strobe, score the byte and schedule a finish pulse
    always @(negedge clk_uart) begin
        model_fin = 1'b0;
        if (enable_tx_o === 1'b0) begin
            strobe_cnt++;
            check("strobe_width", {31'b0, prev_en}, 32'd1);
            if (exp_q.size() == 0) begin
                check("strobe_expected", exp_q.size(), 32'd1);
            end else begin
                model_exp = exp_q.pop_front();
                check("byte", 32'(uart_byte_o), 32'(model_exp));
            end
            if (model_on) fin_timer = frame_len;
        end else if (fin_timer > 0) begin
            fin_timer--;
            if (fin_timer == 0) model_fin = 1'b1;
        end
        prev_en = enable_tx_o;
    end

    // Drive one word for one cycle; its bytes are scoreboarded only if accepted
    task automatic push_word(input logic [31:0] w, output bit acc);
        acc          = (word_ready_o === 1'b1);
        word_i       = w;
        word_valid_i = 1'b1;
        if (acc) begin
            for (int b = 0; b < WORD_W / 8; b++) exp_q.push_back(w[8*b +: 8]);
        end
        @(posedge clk_uart);
        @(negedge clk_uart);
        word_valid_i = 1'b0;
    endtask

    task automatic wait_words(input int target, input int budget);
        int n = 0;
        while (words_sent_o !== 16'(target) && n < budget) begin
            @(negedge clk_uart);
            n++;
        end
        check("words_sent", 32'(words_sent_o), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   acc;
        int   k;
        int   base;
        logic [31:0] w;

        rst          = 1'b1;
        word_i       = '0;
        word_valid_i = 1'b0;
        repeat (2) @(posedge clk_uart);
        @(negedge clk_uart);
        check("rst_enable",  32'(enable_tx_o),   32'd1);
        check("rst_byte",    32'(uart_byte_o),   32'd0);
        check("rst_busy",    32'(busy_o),        32'd0);
        check("rst_err",     32'(timeout_err_o), 32'd0);
        check("rst_words",   32'(words_sent_o),  32'd0);
        check("rst_ready",   32'(word_ready_o),  32'd1);
        check("rst_count",   32'(fifo_count_o),  32'd0);
        rst = 1'b0;

        // Single word into an idle block: D4, C3, B2, A1
        push_word(32'hA1B2C3D4, acc);
        check("t1_accept", 32'(acc), 32'd1);
        check("t1_count",  32'(fifo_count_o), 32'd1);
        @(negedge clk_uart);
        check("t1_setup_busy", 32'(busy_o),      32'd1);
        check("t1_setup_byte", 32'(uart_byte_o), 32'hD4);
        check("t1_setup_en",   32'(enable_tx_o), 32'd1);
        @(negedge clk_uart);
        check("t1_strobe_latency", 32'(enable_tx_o), 32'd0);
        wait_words(1, 300);
        check("t1_strobes", 32'(strobe_cnt), 32'd4);
        check("t1_q_empty", exp_q.size(), 32'd0);

        // Fill the FIFO behind a slow first frame; one word is in flight
        frame_len = 40;
        for (int i = 0; i < 9; i++) begin
            push_word(32'h10203040 + 32'(i) * 32'h01010101, acc);
            check("t2_accept", 32'(acc), 32'd1);
        end
        check("t2_count_full", 32'(fifo_count_o), 32'd8);
        check("t2_ready_low",  32'(word_ready_o), 32'd0);
        push_word(32'hDEADBEEF, acc);
        check("t2_reject",     32'(acc), 32'd0);
        check("t2_count_hold", 32'(fifo_count_o), 32'd8);
        frame_len = 6;
        wait_words(10, 6000);
        check("t2_q_empty", exp_q.size(), 32'd0);

        // Push coinciding with the pop of the only queued word
        push_word(32'h55AA33CC, acc);
        check("t3_count1", 32'(fifo_count_o), 32'd1);
        check("t3_idle",   32'(busy_o),       32'd0);
        push_word(32'h0F1E2D3C, acc);
        check("t3_count_same", 32'(fifo_count_o), 32'd1);
        check("t3_busy",       32'(busy_o),       32'd1);
        wait_words(12, 1000);
        check("t3_q_empty", exp_q.size(), 32'd0);

        // Hung transmitter on the first word, healthy for the second
        model_on = 1'b0;
        push_word(32'h99887766, acc);
        push_word(32'h44332211, acc);
        k = 0;
        while (enable_tx_o !== 1'b0 && k < 10) begin
            @(negedge clk_uart);
            k++;
        end
        check("t4_strobe_seen", 32'(enable_tx_o), 32'd0);
        k = 0;
        do begin
            @(negedge clk_uart);
            k++;
        end while (timeout_err_o !== 1'b1 && k < 200);
        // One START cycle plus TIMEOUT WAIT cycles before the flag shows
        check("t4_timeout_cycles", 32'(k), 32'(TIMEOUT + 1));
        check("t4_idle", 32'(busy_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (exp_q.size() > 0) exp_q.delete(0);
        end
        model_on = 1'b1;
        wait_words(13, 500);
        check("t4_flag_sticky", 32'(timeout_err_o), 32'd1);
        check("t4_q_empty", exp_q.size(), 32'd0);

        // Reset during byte 2 with three words queued behind
        base = strobe_cnt;
        for (int i = 0; i < 4; i++) push_word(32'hC0C1C2C3 + 32'(i), acc);
        k = 0;
        while (strobe_cnt < base + 3 && k < 500) begin
            @(negedge clk_uart);
            k++;
        end
        check("t5_reach_byte2", 32'(strobe_cnt), 32'(base + 3));
        @(negedge clk_uart);
        rst = 1'b1;
        @(negedge clk_uart);
        check("t5_enable", 32'(enable_tx_o),   32'd1);
        check("t5_count",  32'(fifo_count_o),  32'd0);
        check("t5_busy",   32'(busy_o),        32'd0);
        check("t5_err",    32'(timeout_err_o), 32'd0);
        check("t5_words",  32'(words_sent_o),  32'd0);
        rst = 1'b0;
        exp_q.delete();
        base = strobe_cnt;
        repeat (100) @(negedge clk_uart);
        check("t5_no_strobe", 32'(strobe_cnt),   32'(base));
        check("t5_still_idle", 32'(busy_o),      32'd0);

        // Stray finish pulses in IDLE and in SETUP are ignored
        manual_fin = 1'b1;
        @(negedge clk_uart);
        manual_fin = 1'b0;
        check("t6_idle_busy",  32'(busy_o),       32'd0);
        check("t6_idle_words", 32'(words_sent_o), 32'd0);
        check("t6_idle_count", 32'(fifo_count_o), 32'd0);
        w = 32'h7E5D3C1B;
        push_word(w, acc);
        @(negedge clk_uart);
        check("t6_in_setup", 32'(busy_o), 32'd1);
        manual_fin = 1'b1;
        @(negedge clk_uart);
        manual_fin = 1'b0;
        check("t6_strobe", 32'(enable_tx_o), 32'd0);
        check("t6_byte0",  32'(uart_byte_o), 32'(w[7:0]));
        wait_words(1, 300);
        check("t6_strobes", 32'(strobe_cnt), 32'(base + 4));
        check("t6_q_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
